// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the data-memory access path.
// Contents:
//   bus_state_e       - state encoding of the data-bus access sequencer
//   SZ_B, SZ_H, SZ_W  - access size codes carried on mem_size / data_size
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    RESP   = 3'd3,
    CANCEL = 3'd4
  } bus_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/data_bus_ctrl.sv
// MEM-stage data-memory access sequencer for the SRAM-like data bus.
// It captures a load/store from the MEM stage and runs the req / addr_ok /
// data_ok handshake. It holds the returned read data until MEM/WB takes it,
// stalls the upstream segments while an access is in flight, and cancels
// flushed accesses without withdrawing a bus request.
// Ports:
//   clk, reset        - pipeline clock, asynchronous active-high reset
//   mem_valid/ren/wen - MEM-stage instruction valid, load, store
//   mem_size/addr/wdata - access size, byte address, lane-aligned store data
//   ex_flush          - exception/eret flush of MEM and older stages
//   wb_allowin        - MEM/WB segment can accept this cycle
//   mem_stall         - freeze IF..EX/MEM (combinational)
//   mem_done          - access complete, MEM/WB captures (combinational)
//   mem_rdata         - registered read data, valid with mem_done
//   data_req/wr/size/addr/wdata - registered bus request
//   data_addr_ok, data_data_ok, data_rdata - bus handshakes and read data
module data_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              ex_flush,
  input  logic              wb_allowin,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  bus_state_e        state_q, state_d;
  logic              cancel_pend_q, cancel_pend_d;
  logic              data_req_q, data_req_d;
  logic              data_wr_q, data_wr_d;
  logic [1:0]        data_size_q, data_size_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [DATA_W-1:0] data_wdata_q, data_wdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_access;
  logic              start;

  assign mem_access = mem_valid & (mem_ren | mem_wen);
  assign start      = mem_access & ~ex_flush;

  // State and bus-request registers; reset may arrive mid-access and simply
  // drops everything, including any request currently on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cancel_pend_q <= 1'b0;
      data_req_q    <= 1'b0;
      data_wr_q     <= 1'b0;
      data_size_q   <= '0;
      data_addr_q   <= '0;
      data_wdata_q  <= '0;
      mem_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cancel_pend_q <= cancel_pend_d;
      data_req_q    <= data_req_d;
      data_wr_q     <= data_wr_d;
      data_size_q   <= data_size_d;
      data_addr_q   <= data_addr_d;
      data_wdata_q  <= data_wdata_d;
      mem_rdata_q   <= mem_rdata_d;
    end
  end

  // Next-state and output decode. A flush can never pull back a request that
  // has not yet seen addr_ok, so it is remembered in cancel_pend and acted on
  // when the address phase completes; after that the outstanding data_ok is
  // swallowed in CANCEL. data_ok seen in any other state is ignored.
  always_comb begin
    state_d       = state_q;
    cancel_pend_d = cancel_pend_q;
    data_req_d    = data_req_q;
    data_wr_d     = data_wr_q;
    data_size_d   = data_size_q;
    data_addr_d   = data_addr_q;
    data_wdata_d  = data_wdata_q;
    mem_rdata_d   = mem_rdata_q;
    mem_done      = 1'b0;
    mem_stall     = 1'b0;

    case (state_q)
      IDLE: begin
        mem_stall = start;
        if (start) begin
          data_req_d   = 1'b1;
          data_wr_d    = mem_wen;
          data_size_d  = mem_size;
          data_addr_d  = mem_addr;
          data_wdata_d = mem_wdata;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        mem_stall = 1'b1;
        if (data_addr_ok) begin
          data_req_d = 1'b0;
          state_d    = (ex_flush | cancel_pend_q) ? CANCEL : DATA;
        end else if (ex_flush) begin
          cancel_pend_d = 1'b1;
        end
      end
      DATA: begin
        mem_stall = 1'b1;
        if (data_data_ok) begin
          if (ex_flush) begin
            state_d = IDLE;
          end else begin
            mem_rdata_d = data_rdata;
            state_d     = RESP;
          end
        end else if (ex_flush) begin
          state_d = CANCEL;
        end
      end
      RESP: begin
        mem_done  = ~ex_flush;
        mem_stall = ~wb_allowin;
        if (ex_flush || wb_allowin) begin
          state_d = IDLE;
        end
      end
      CANCEL: begin
        mem_stall = mem_access;
        if (data_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        data_req_d = 1'b0;
      end
    endcase

    if (state_d == IDLE || state_d == CANCEL) begin
      cancel_pend_d = 1'b0;
    end
  end

  assign mem_rdata  = mem_rdata_q;
  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Self-checking bench for data_bus_ctrl: directed cycle-by-cycle stimulus,
// a scoreboard queue of expected read data popped by a monitor on mem_done,
// and a protocol check on data_ok arriving outside an access.
module tb_data_bus_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid, mem_ren, mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        ex_flush, wb_allowin;
  logic        mem_stall, mem_done;
  logic [31:0] mem_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_val;
  logic        stray_ok = 1'b0;

  data_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ex_flush(ex_flush), .wb_allowin(wb_allowin),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    else
      pass_cnt++;
  endtask

  task automatic applyStimulus(input logic valid, input logic ren, input logic wen,
                               input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic flush,
                               input logic wb);
    mem_valid  = valid;
    mem_ren    = ren;
    mem_wen    = wen;
    mem_size   = size;
    mem_addr   = addr;
    mem_wdata  = wdata;
    ex_flush   = flush;
    wb_allowin = wb;
  endtask

  task automatic driveBus(input logic aok, input logic dok, input logic [31:0] rdata);
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata   = rdata;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every mem_done cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && mem_done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL unexpected_done: mem_done=1 rdata=%h, expected mem_done=0",
                 mem_rdata);
      end else begin
        exp_val = exp_q.pop_front();
        checkOutput("done_rdata", mem_rdata, exp_val);
      end
    end
  end

  // Bus protocol: data_ok only belongs in DATA or CANCEL.
  always @(negedge clk) begin
    if (!reset && data_data_ok && !stray_ok)
      assert (dut.state_q == DATA || dut.state_q == CANCEL)
        else $error("[TB] data_ok outside DATA/CANCEL");
  end

  initial begin
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 0, 1);
    driveBus(0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", data_req, 0);
    checkOutput("rst_wr", data_wr, 0);
    checkOutput("rst_size", data_size, 0);
    checkOutput("rst_addr", data_addr, 0);
    checkOutput("rst_wdata", data_wdata, 0);
    checkOutput("rst_rdata", mem_rdata, 0);
    checkOutput("rst_done", mem_done, 0);
    checkOutput("rst_stall", mem_stall, 0);
    checkOutput("rst_state", dut.state_q, IDLE);
    reset = 1'b0;
    nextCycle;

    // Test 1: load word 0x1000, zero-wait bus
    applyStimulus(1, 1, 0, SZ_W, 32'h1000, 0, 0, 1);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t1_c0_stall", mem_stall, 1);
    checkOutput("t1_c0_req", data_req, 0);
    nextCycle;
    driveBus(1, 0, 0);
    @(negedge clk);
    checkOutput("t1_c1_req", data_req, 1);
    checkOutput("t1_c1_wr", data_wr, 0);
    checkOutput("t1_c1_size", data_size, SZ_W);
    checkOutput("t1_c1_addr", data_addr, 32'h1000);
    checkOutput("t1_c1_stall", mem_stall, 1);
    nextCycle;
    driveBus(0, 1, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t1_c2_req", data_req, 0);
    checkOutput("t1_c2_stall", mem_stall, 1);
    checkOutput("t1_c2_done", mem_done, 0);
    nextCycle;
    driveBus(0, 0, 0);
    @(negedge clk);
    checkOutput("t1_c3_done", mem_done, 1);
    checkOutput("t1_c3_stall", mem_stall, 0);
    nextCycle;
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t1_c4_done", mem_done, 0);
    nextCycle;

    // Test 2: store byte 0x2003, addr_ok after 3 wait cycles
    applyStimulus(1, 0, 1, SZ_B, 32'h2003, 32'h000000AA, 0, 1);
    exp_q.push_back(32'h0BADF00D);
    @(negedge clk);
    checkOutput("t2_c0_stall", mem_stall, 1);
    nextCycle;
    for (int i = 1; i <= 4; i++) begin
      driveBus(i == 4, 0, 0);
      @(negedge clk);
      checkOutput("t2_req", data_req, 1);
      checkOutput("t2_wr", data_wr, 1);
      checkOutput("t2_size", data_size, SZ_B);
      checkOutput("t2_addr", data_addr, 32'h2003);
      checkOutput("t2_wdata", data_wdata, 32'h000000AA);
      checkOutput("t2_stall", mem_stall, 1);
      nextCycle;
    end
    driveBus(0, 1, 32'h0BADF00D);
    @(negedge clk);
    checkOutput("t2_c5_req", data_req, 0);
    checkOutput("t2_c5_done", mem_done, 0);
    nextCycle;
    driveBus(0, 0, 32'hFFFFFFFF);
    @(negedge clk);
    checkOutput("t2_c6_done", mem_done, 1);
    nextCycle;
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 0, 1);
    nextCycle;

    // Test 3: flush in ADDR before addr_ok, then cancelled data_ok
    applyStimulus(1, 1, 0, SZ_W, 32'h3000, 0, 0, 1);
    @(negedge clk);
    checkOutput("t3_c0_stall", mem_stall, 1);
    nextCycle;
    applyStimulus(1, 1, 0, SZ_W, 32'h3000, 0, 1, 1);
    @(negedge clk);
    checkOutput("t3_c1_req", data_req, 1);
    checkOutput("t3_c1_stall", mem_stall, 1);
    nextCycle;
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t3_c2_req", data_req, 1);
    checkOutput("t3_c2_addr", data_addr, 32'h3000);
    nextCycle;
    driveBus(1, 0, 0);
    @(negedge clk);
    checkOutput("t3_c3_req", data_req, 1);
    nextCycle;
    driveBus(0, 0, 0);
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 1, 1);
    @(negedge clk);
    checkOutput("t3_c4_req", data_req, 0);
    checkOutput("t3_c4_stall", mem_stall, 0);
    checkOutput("t3_c4_state", dut.state_q, CANCEL);
    nextCycle;
    applyStimulus(1, 1, 0, SZ_W, 32'h3100, 0, 0, 1);
    driveBus(0, 1, 32'h12345678);
    @(negedge clk);
    checkOutput("t3_c5_state", dut.state_q, CANCEL);
    checkOutput("t3_c5_stall", mem_stall, 1);
    checkOutput("t3_c5_done", mem_done, 0);
    nextCycle;
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 0, 1);
    driveBus(0, 0, 0);
    @(negedge clk);
    checkOutput("t3_c6_state", dut.state_q, IDLE);
    checkOutput("t3_c6_rdata", mem_rdata, 32'h0BADF00D);
    checkOutput("t3_c6_done", mem_done, 0);
    nextCycle;

    // Test 4: RESP held by wb_allowin low for two cycles
    applyStimulus(1, 1, 0, SZ_W, 32'h4000, 0, 0, 1);
    repeat (3) exp_q.push_back(32'hCAFEF00D);
    nextCycle;
    driveBus(1, 0, 0);
    nextCycle;
    driveBus(0, 1, 32'hCAFEF00D);
    nextCycle;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, SZ_W, 32'h4000, 0, 0, i == 2);
      driveBus(0, 0, 32'h99999999);
      @(negedge clk);
      checkOutput("t4_done", mem_done, 1);
      checkOutput("t4_stall", mem_stall, i != 2);
      nextCycle;
    end
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t4_idle_done", mem_done, 0);
    checkOutput("t4_idle_state", dut.state_q, IDLE);
    nextCycle;

    // Test 5: flush coincident with data_ok, then immediate new load
    applyStimulus(1, 1, 0, SZ_W, 32'h5000, 0, 0, 1);
    nextCycle;
    driveBus(1, 0, 0);
    nextCycle;
    applyStimulus(1, 1, 0, SZ_W, 32'h5000, 0, 1, 1);
    driveBus(0, 1, 32'h11112222);
    @(negedge clk);
    checkOutput("t5_c2_done", mem_done, 0);
    nextCycle;
    applyStimulus(1, 1, 0, SZ_W, 32'h6000, 0, 0, 1);
    driveBus(0, 0, 0);
    exp_q.push_back(32'h600D600D);
    @(negedge clk);
    checkOutput("t5_c3_state", dut.state_q, IDLE);
    checkOutput("t5_c3_stall", mem_stall, 1);
    checkOutput("t5_c3_req", data_req, 0);
    nextCycle;
    driveBus(1, 0, 0);
    @(negedge clk);
    checkOutput("t5_c4_req", data_req, 1);
    checkOutput("t5_c4_addr", data_addr, 32'h6000);
    nextCycle;
    driveBus(0, 1, 32'h600D600D);
    nextCycle;
    driveBus(0, 0, 0);
    @(negedge clk);
    checkOutput("t5_c6_done", mem_done, 1);
    nextCycle;
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 0, 1);
    nextCycle;

    // Test 6: asynchronous reset while in DATA, then a stray data_ok
    applyStimulus(1, 1, 0, SZ_W, 32'h7000, 0, 0, 1);
    nextCycle;
    driveBus(1, 0, 0);
    nextCycle;
    driveBus(0, 0, 0);
    @(negedge clk);
    checkOutput("t6_state_data", dut.state_q, DATA);
    #1;
    reset = 1'b1;
    applyStimulus(0, 0, 0, SZ_W, 0, 0, 0, 1);
    #1;
    checkOutput("t6_rst_req", data_req, 0);
    checkOutput("t6_rst_addr", data_addr, 0);
    checkOutput("t6_rst_rdata", mem_rdata, 0);
    checkOutput("t6_rst_state", dut.state_q, IDLE);
    checkOutput("t6_rst_done", mem_done, 0);
    checkOutput("t6_rst_stall", mem_stall, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    nextCycle;
    stray_ok = 1'b1;
    driveBus(0, 1, 32'hBAD0BAD0);
    @(negedge clk);
    checkOutput("t6_stray_done", mem_done, 0);
    nextCycle;
    driveBus(0, 0, 0);
    stray_ok = 1'b0;
    @(negedge clk);
    checkOutput("t6_post_done", mem_done, 0);
    checkOutput("t6_post_state", dut.state_q, IDLE);
    checkOutput("t6_post_rdata", mem_rdata, 0);
    nextCycle;

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
